// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: walks the register file debug read port over every
// address and streams each register to the debug UART, one byte at a time,
// most significant byte first. All outputs come straight from flops.
module regfile_dump_ctrl #(
  parameter int B  = 32,  // register width, multiple of NB
  parameter int W  = 5,   // register address width
  parameter int NB = 8    // transmitted byte width
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [B-1:0]  i_reg_data,
  input  logic          i_tx_done,
  output logic [W-1:0]  o_reg_addr,
  output logic [NB-1:0] o_tx_data,
  output logic          o_tx_start,
  output logic          o_busy,
  output logic          o_done
);

  localparam int NBYTES = B / NB;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [W-1:0]  LAST_ADDR = {W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [B-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [NB-1:0]  tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // State and datapath registers; reset returns everything to a quiet IDLE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; busy/done are derived from the next state so the
  // registered flags line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Address has been stable for a full cycle, so the async read settled.
        shift_d = i_reg_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_data_d  = shift_q[B-1 -: NB];
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving together with the start pulse is accepted here too.
        if (i_tx_done) begin
          if (cnt_q == LAST_BYTE) begin
            state_d = S_NEXT;
          end else begin
            shift_d = shift_q << NB;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign o_reg_addr = addr_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: register file and UART TX are
// modelled here; the byte stream is compared with one built from the regs.
module tb_regfile_dump_ctrl;
  localparam int B      = 32;
  localparam int W      = 5;
  localparam int NB     = 8;
  localparam int NREG   = 32;
  localparam int NBYTES = 4;
  localparam int TOTAL  = NREG * NBYTES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          spur = 1'b0;
  logic          model_done = 1'b0;
  logic          tx_done;
  logic [B-1:0]  reg_data;
  logic [W-1:0]  reg_addr;
  logic [NB-1:0] tx_data;
  logic          tx_start;
  logic          busy;
  logic          done;

  logic [B-1:0]  regs [NREG];

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int delay_mode = 3;  // <0: random 0..10 cycles, else fixed delay
  bit pend = 0;
  int cd = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         got_addr[$];

  assign reg_data = regs[reg_addr];
  assign tx_done  = model_done | spur;

  regfile_dump_ctrl #(.B(B), .W(W), .NB(NB)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_reg_data (reg_data),
    .i_tx_done  (tx_done),
    .o_reg_addr (reg_addr),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART TX model: logs every launched byte and answers with a done pulse.
  initial forever begin
    @(negedge clk);
    model_done = 1'b0;
    if (tx_start) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cyc);
      got_addr.push_back(int'(reg_addr));
      pend = 1;
      cd = (delay_mode < 0) ? int'($urandom_range(10, 0)) : delay_mode;
    end else if (pend && cd > 0) begin
      cd--;
    end
    if (pend && cd == 0) begin
      model_done = 1'b1;
      pend = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    got_addr.delete();
    pend = 0;
  endtask

  // Reference stream: registers in address order, each MSB byte first.
  task automatic verify_stream(input string tag);
    logic [7:0] exp_q[$];
    for (int r = 0; r < NREG; r++)
      for (int k = NBYTES - 1; k >= 0; k--)
        exp_q.push_back(regs[r][k*8 +: 8]);
    check({tag, "_byte_count"}, got_q.size(), TOTAL);
    for (int i = 0; i < TOTAL && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // One full dump; optionally pokes i_start while busy and i_tx_done in IDLE/LOAD.
  task automatic run_dump(input string tag, input bit inject);
    int  done_seen;
    bit  finished;
    done_seen = 0;
    finished  = 0;
    clear_log();
    @(negedge clk);
    start = 1'b1;
    spur  = inject;           // IDLE cycle
    @(negedge clk);
    start = 1'b0;
    spur  = inject;           // LOAD cycle
    @(negedge clk);
    spur  = 1'b0;
    for (int i = 0; i < 6000 && !finished; i++) begin
      @(negedge clk);
      if (inject) start = busy && ($urandom_range(3, 0) == 0);
      if (done) begin
        finished = 1;
        done_seen++;
        check({tag, "_busy_in_done"}, busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_done"}, busy, 1'b0);
        check({tag, "_addr_after_done"}, reg_addr, '0);
        for (int j = 0; j < 5; j++) begin
          if (done) done_seen++;
          @(negedge clk);
        end
        check({tag, "_done_pulses"}, done_seen, 1);
        check({tag, "_idle_after"}, busy, 1'b0);
      end
    end
    start = 1'b0;
    if (!finished) check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  typedef struct {
    int dmode;
    bit inject;
    bit formula;
    bit b2b;
  } run_t;

  run_t runs [4];

  initial begin
    int start_cyc;
    int bad;
    bit hit;

    runs[0].dmode = -1; runs[0].inject = 0; runs[0].formula = 1; runs[0].b2b = 0;
    runs[1].dmode = 0;  runs[1].inject = 0; runs[1].formula = 0; runs[1].b2b = 1;
    runs[2].dmode = -1; runs[2].inject = 1; runs[2].formula = 0; runs[2].b2b = 0;
    runs[3].dmode = 0;  runs[3].inject = 1; runs[3].formula = 1; runs[3].b2b = 1;

    for (int i = 0; i < NREG; i++) regs[i] = $urandom;

    // Reset, then idle with no start
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {busy, tx_start, reg_addr, done, tx_data}, '0);
    end

    // Single-register byte order with a fixed 3-cycle TX
    regs[0] = 32'hA1B2C3D4;
    delay_mode = 3;
    clear_log();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && got_q.size() < 5; i++) @(negedge clk);
    check("first_latency", got_cyc.size() > 0 ? got_cyc[0] - start_cyc : -1, 3);
    check("order_b0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'hA1);
    check("order_b1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'hB2);
    check("order_b2", got_q.size() > 2 ? got_q[2] : 8'hxx, 8'hC3);
    check("order_b3", got_q.size() > 3 ? got_q[3] : 8'hxx, 8'hD4);
    check("addr_at_5th", got_addr.size() > 4 ? got_addr[4] : -1, 1);
    hit = 0;
    for (int i = 0; i < 6000 && !hit; i++) begin
      @(negedge clk);
      if (done) hit = 1;
    end
    check("single_run_done", hit, 1'b1);
    @(negedge clk);

    // Table of full dumps
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++)
        regs[i] = runs[r].formula ? (32'(i) * 32'h0100_0000 + 32'(i)) : 32'($urandom);
      delay_mode = runs[r].dmode;
      run_dump($sformatf("run%0d", r), runs[r].inject);
      verify_stream($sformatf("run%0d", r));
      if (runs[r].b2b) begin
        bad = 0;
        for (int i = 1; i < got_cyc.size(); i++)
          if (got_cyc[i] - got_cyc[i-1] != ((i % NBYTES == 0) ? 4 : 2)) bad++;
        check($sformatf("run%0d_b2b_spacing", r), bad, 0);
      end
    end

    // Reset in the middle of a dump, while at register 7 in WAIT
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    delay_mode = 3;
    clear_log();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (reg_addr == 5'd7 && tx_start) hit = 1;
    end
    check("reached_addr7", hit, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {busy, tx_start, reg_addr, done, tx_data}, '0);
    rst = 1'b0;
    pend = 0;
    repeat (3) @(negedge clk);
    check("midreset_still_idle", busy, 1'b0);
    delay_mode = -1;
    run_dump("restart", 1'b0);
    check("restart_first_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, regs[0][31:24]);
    verify_stream("restart");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
